// File: rtl/fir_mac_multich.sv
// fir_mac_multich: time-multiplexed FIR multiply-accumulate engine for the
// equalizer band path. One sample per channel arrives per sequencing cycle,
// coefficients come from an external band ROM, and all channels accumulate
// in parallel. One scaled word per channel is emitted with a 1-cycle valid.
//
// Build option: define FIR_MAC_SAT_EN to saturate the scaled accumulator to
// the DATA_W signed range; otherwise the low DATA_W bits are kept (wrap).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a frame; coeff_addr parked at 0 so coeff[0] is ready
// MAC   | accumulating one tap per sequencing cycle
// DONE  | scale accumulators into smpl_out, pulse valid, rewind coeff_addr
// HOLD  | frame ran past NUM_TAPS; ignore samples until sequencing drops
module fir_mac_multich #(
    parameter int DATA_W    = 16,
    parameter int COEFF_W   = 16,
    parameter int NUM_TAPS  = 1021,
    parameter int NUM_CH    = 2,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 15,
    localparam int ADDR_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sequencing,
    input  logic [NUM_CH*DATA_W-1:0] smpl_in,
    output logic [ADDR_W-1:0]        coeff_addr,
    input  logic [COEFF_W-1:0]       coeff,
    output logic [NUM_CH*DATA_W-1:0] smpl_out,
    output logic                     valid,
    output logic                     busy
);

    localparam int CNT_W  = $clog2(NUM_TAPS + 1);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic acc_load;
    logic acc_add;
    logic out_upd;
    logic addr_inc;

    logic [CNT_W-1:0]         tap_cnt;
    logic signed [ACC_W-1:0]  acc      [NUM_CH];
    logic signed [PROD_W-1:0] prod     [NUM_CH];
    logic signed [ACC_W-1:0]  prod_ext [NUM_CH];
    logic [DATA_W-1:0]        out_word [NUM_CH];

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] shifted [NUM_CH];
`endif

    // Signed per-channel product, sign-extended to accumulator width.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c]     = PROD_W'($signed(smpl_in[c*DATA_W +: DATA_W])) *
                          PROD_W'($signed(coeff));
            prod_ext[c] = ACC_W'(prod[c]);
        end
    end

    // Arithmetic scale of each accumulator down to an output word.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef FIR_MAC_SAT_EN
            shifted[c] = acc[c] >>> FRAC_BITS;
            if (shifted[c] > SAT_MAX) begin
                out_word[c] = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (shifted[c] < SAT_MIN) begin
                out_word[c] = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                out_word[c] = shifted[c][DATA_W-1:0];
            end
`else
            out_word[c] = DATA_W'(acc[c] >>> FRAC_BITS);
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        acc_load  = 1'b0;
        acc_add   = 1'b0;
        out_upd   = 1'b0;
        addr_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sequencing) begin
                    acc_load  = 1'b1;
                    addr_inc  = 1'b1;
                    state_nxt = (NUM_TAPS == 1) ? S_DONE : S_MAC;
                end
            end
            S_MAC: begin
                if (sequencing) begin
                    acc_add  = 1'b1;
                    addr_inc = 1'b1;
                    if (tap_cnt == CNT_LAST) begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    // Short frame: the partial sum is what gets reported.
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_upd   = 1'b1;
                state_nxt = sequencing ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!sequencing) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Tap counter and ROM address; the address parks on the last tap so it
    // never points past the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt    <= '0;
            coeff_addr <= '0;
        end else begin
            if (acc_load) begin
                tap_cnt <= CNT_W'(1);
            end else if (acc_add) begin
                tap_cnt <= tap_cnt + CNT_W'(1);
            end else if (out_upd) begin
                tap_cnt <= '0;
            end

            if (out_upd) begin
                coeff_addr <= '0;
            end else if (addr_inc && (coeff_addr != ADDR_LAST)) begin
                coeff_addr <= coeff_addr + ADDR_W'(1);
            end
        end
    end

    // Accumulators: first tap loads directly, later taps add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc_load) begin
                    acc[c] <= prod_ext[c];
                end else if (acc_add) begin
                    acc[c] <= acc[c] + prod_ext[c];
                end
            end
        end
    end

    // Result register and its one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= out_upd;
            if (out_upd) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    smpl_out[c*DATA_W +: DATA_W] <= out_word[c];
                end
            end
        end
    end

    // Busy whenever a frame is in flight or being drained.
    always_comb begin
        busy = (state != S_IDLE);
    end

endmodule

// File: tb/tb_fir_mac_multich.sv
// Self-checking bench for fir_mac_multich (NUM_TAPS=4, NUM_CH=2).
// A frame-level reference model predicts outputs each cycle; directed
// scenarios add hand-computed literals that pin both DUT and model.
module tb_fir_mac_multich;

    localparam int DATA_W    = 16;
    localparam int COEFF_W   = 16;
    localparam int NUM_TAPS  = 4;
    localparam int NUM_CH    = 2;
    localparam int ACC_W     = 40;
    localparam int FRAC_BITS = 15;

`ifdef FIR_MAC_SAT_EN
    localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
    localparam logic [15:0] SAT_EXP = 16'hFFF8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sequencing;
    logic [31:0] smpl_in;
    logic [1:0]  coeff_addr;
    logic [15:0] coeff;
    logic [31:0] smpl_out;
    logic        valid;
    logic        busy;

    // Band ROM: coeff follows the registered address, so tap k is on coeff
    // in the cycle the engine holds address k.
    logic [15:0] rom [NUM_TAPS];
    assign coeff = rom[coeff_addr];

    fir_mac_multich #(
        .DATA_W    (DATA_W),
        .COEFF_W   (COEFF_W),
        .NUM_TAPS  (NUM_TAPS),
        .NUM_CH    (NUM_CH),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .smpl_out   (smpl_out),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int tcyc  = 0;
    int n_valid = 0;
    int last_valid_cyc = -1;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int          m_cyc      = 0;
    bit          m_coll     = 0;
    bit          m_rel      = 0;
    int          m_free_at  = 0;
    int          m_start_at = 0;
    int          m_done_at  = -1;
    int          m_valid_at = -1;
    int          m_taps     = 0;
    longint      m_acc [NUM_CH];
    logic [31:0] m_pend     = '0;
    logic [31:0] exp_out    = '0;
    longint      m_aw;
    longint      m_sh;
    logic [15:0] m_o;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_coll     = 0;
                m_rel      = 0;
                m_free_at  = 0;
                m_done_at  = -1;
                m_valid_at = -1;
                m_taps     = 0;
                exp_out    = '0;
            end else begin
                if (!m_coll && !m_rel && m_cyc >= m_free_at && sequencing) begin
                    m_coll     = 1;
                    m_taps     = 0;
                    m_start_at = m_cyc;
                    m_free_at  = 32'h3FFF_FFFF;
                    for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
                end
                if (m_rel && m_cyc >= m_done_at && !sequencing) begin
                    m_rel     = 0;
                    m_free_at = m_cyc + 1;
                end
                if (m_coll) begin
                    if (sequencing && m_taps < NUM_TAPS) begin
                        for (int c = 0; c < NUM_CH; c++)
                            m_acc[c] += longint'($signed(smpl_in[c*16 +: 16])) *
                                        longint'($signed(rom[m_taps]));
                        m_taps++;
                    end
                    if (!sequencing || m_taps == NUM_TAPS) begin
                        m_coll     = 0;
                        m_rel      = 1;
                        m_done_at  = m_cyc + 1;
                        m_valid_at = m_cyc + 2;
                        for (int c = 0; c < NUM_CH; c++) begin
                            m_aw = (m_acc[c] <<< (64 - ACC_W)) >>> (64 - ACC_W);
                            m_sh = m_aw >>> FRAC_BITS;
`ifdef FIR_MAC_SAT_EN
                            if (m_sh > 32767)       m_o = 16'h7FFF;
                            else if (m_sh < -32768) m_o = 16'h8000;
                            else                    m_o = m_sh[15:0];
`else
                            m_o = m_sh[15:0];
`endif
                            m_pend[c*16 +: 16] = m_o;
                        end
                    end
                end
                m_cyc = m_cyc + 1;
                if (m_cyc == m_valid_at) exp_out = m_pend;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    logic [63:0] e_addr;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_coll)                 e_addr = 64'(m_taps);
            else if (m_cyc == m_done_at) e_addr = 64'((m_taps > NUM_TAPS-1) ? NUM_TAPS-1 : m_taps);
            else                         e_addr = 0;
            chk("cyc_valid", 64'(valid), 64'(m_cyc == m_valid_at));
            chk("cyc_busy", 64'(busy), 64'((m_cyc > m_start_at) && (m_cyc < m_free_at)));
            chk("cyc_out", 64'(smpl_out), 64'(exp_out));
            chk("cyc_addr", 64'(coeff_addr), e_addr);
            if (valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = tcyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit seq, input logic [15:0] s0, input logic [15:0] s1);
        @(negedge clk);
        sequencing = seq;
        smpl_in    = {s1, s0};
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0, 16'h0);
    endtask

    task automatic set_rom(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    int v0;
    int ls;

    initial begin
        rst_n      = 1'b0;
        sequencing = 1'b0;
        smpl_in    = '0;
        set_rom(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out", 64'(smpl_out), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_addr", 64'(coeff_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Basic sum: 0x2000*0x4000 + 0x2000*0x2000 = 0xC000000 -> >>15 = 0x1800.
        set_rom(16'h4000, 16'h2000, 16'h0000, 16'h0000);
        v0 = n_valid;
        drive(1'b1, 16'h2000, 16'h0);
        drive(1'b1, 16'h2000, 16'h0);
        drive(1'b1, 16'h0, 16'h0);
        drive(1'b1, 16'h0, 16'h0);
        ls = tcyc;
        idle(5);
        chk("basic_ch0", 64'(smpl_out[15:0]), 64'h1800);
        chk("basic_ch1", 64'(smpl_out[31:16]), 64'h0);
        chk("basic_ch0_model", 64'(exp_out[15:0]), 64'h1800);
        chk("basic_nvalid", 64'(n_valid - v0), 64'd1);
        chk("basic_latency", 64'(last_valid_cyc - ls), 64'd2);

        // Channel independence: ch1 = -0x2000 pair gives -0x1800 = 0xE800.
        v0 = n_valid;
        drive(1'b1, 16'h2000, 16'hE000);
        drive(1'b1, 16'h2000, 16'hE000);
        drive(1'b1, 16'h0, 16'h0);
        drive(1'b1, 16'h0, 16'h0);
        idle(5);
        chk("chan_ch1", 64'(smpl_out[31:16]), 64'hE800);
        chk("chan_ch0", 64'(smpl_out[15:0]), 64'h1800);
        chk("chan_ch1_model", 64'(exp_out[31:16]), 64'hE800);
        chk("chan_nvalid", 64'(n_valid - v0), 64'd1);

        // Over-length frame: taps 5 and 6 must be ignored.
        v0 = n_valid;
        drive(1'b1, 16'h2000, 16'h0);
        drive(1'b1, 16'h2000, 16'h0);
        drive(1'b1, 16'h0, 16'h0);
        drive(1'b1, 16'h0, 16'h0);
        drive(1'b1, 16'h7FFF, 16'h7FFF);
        #1 chk("ovl_busy5", 64'(busy), 64'h1);
        drive(1'b1, 16'h7FFF, 16'h7FFF);
        #1 chk("ovl_busy6", 64'(busy), 64'h1);
        idle(4);
        chk("ovl_busy_after", 64'(busy), 64'h0);
        chk("ovl_addr", 64'(coeff_addr), 64'h0);
        chk("ovl_ch0", 64'(smpl_out[15:0]), 64'h1800);
        chk("ovl_ch1", 64'(smpl_out[31:16]), 64'h0);
        chk("ovl_nvalid", 64'(n_valid - v0), 64'd1);

        // Saturation: 4 * 0x7FFF^2 = 0xFFFC0004 -> >>15 = 0x1FFF8.
        set_rom(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        repeat (4) drive(1'b1, 16'h7FFF, 16'h7FFF);
        idle(5);
        chk("sat_ch0", 64'(smpl_out[15:0]), 64'(SAT_EXP));
        chk("sat_ch1", 64'(smpl_out[31:16]), 64'(SAT_EXP));
        chk("sat_ch0_model", 64'(exp_out[15:0]), 64'(SAT_EXP));

        // Short frame: two taps only. ch1: 0x4000*0x4000 + 0x1000*0x2000 -> 0x2400.
        set_rom(16'h4000, 16'h2000, 16'h0000, 16'h0000);
        v0 = n_valid;
        drive(1'b1, 16'h2000, 16'h4000);
        drive(1'b1, 16'h2000, 16'h1000);
        idle(6);
        chk("short_ch0", 64'(smpl_out[15:0]), 64'h1800);
        chk("short_ch1", 64'(smpl_out[31:16]), 64'h2400);
        chk("short_ch1_model", 64'(exp_out[31:16]), 64'h2400);
        chk("short_addr", 64'(coeff_addr), 64'h0);
        chk("short_nvalid", 64'(n_valid - v0), 64'd1);

        // Reset mid-frame after two MAC cycles.
        v0 = n_valid;
        drive(1'b1, 16'h2000, 16'hE000);
        drive(1'b1, 16'h2000, 16'hE000);
        drive(1'b1, 16'h0, 16'h0);
        @(negedge clk);
        rst_n      = 1'b0;
        sequencing = 1'b0;
        smpl_in    = '0;
        #1;
        chk("mrst_out", 64'(smpl_out), 64'h0);
        chk("mrst_valid", 64'(valid), 64'h0);
        chk("mrst_busy", 64'(busy), 64'h0);
        chk("mrst_addr", 64'(coeff_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        chk("mrst_nvalid", 64'(n_valid - v0), 64'd0);
        v0 = n_valid;
        drive(1'b1, 16'h2000, 16'h0);
        drive(1'b1, 16'h2000, 16'h0);
        drive(1'b1, 16'h0, 16'h0);
        drive(1'b1, 16'h0, 16'h0);
        idle(5);
        chk("mrst_next_ch0", 64'(smpl_out[15:0]), 64'h1800);
        chk("mrst_next_nvalid", 64'(n_valid - v0), 64'd1);

        // Randomized frames of varied length and gap, including gap 0 and
        // frames that start during DONE/HOLD.
        for (int f = 0; f < 60; f++) begin
            int len;
            int gap;
            if ($urandom_range(0, 1) == 1)
                set_rom(rnd16(), rnd16(), rnd16(), rnd16());
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) drive(1'b1, rnd16(), rnd16());
            gap = $urandom_range(0, 3);
            repeat (gap) drive(1'b0, rnd16(), rnd16());
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
